controller_sequencer: RTL and testbench

CONTROLLER_SEQUENCER -- requirements
Module: controller_sequencer

---
 rtl/controller_sequencer.sv | 171 +++++++++++++++++
 tb/tb_controller_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/controller_sequencer.sv
// Purpose : SAP-style controller/sequencer; a 6-state one-hot ring counter plus opcode decode of the control word.
// Latency : control outputs are a combinational decode of the current T-state and op; t_state/hlt update on every posedge clk.
// Backpressure: none; the ring free-runs until HLT, then holds at T4 until clr. Optional macro CTRL_VAR_CYCLE_EN skips trailing no-op states.
module controller_sequencer #(
  parameter logic [3:0] OP_LDA = 4'b0000,
  parameter logic [3:0] OP_ADD = 4'b0001,
  parameter logic [3:0] OP_SUB = 4'b0010,
  parameter logic [3:0] OP_OUT = 4'b1110,
  parameter logic [3:0] OP_HLT = 4'b1111
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] op,
  output logic [5:0] t_state,
  output logic       Cp,
  output logic       Ep,
  output logic       Lm_n,
  output logic       CE_n,
  output logic       Li_n,
  output logic       Ei_n,
  output logic       La_n,
  output logic       Lb_n,
  output logic       Lo_n,
  output logic       Ea,
  output logic       Su,
  output logic       Eu,
  output logic       hlt
);

  // One-hot encoding doubles as the externally visible ring counter.
  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  t_state_e t_q;

  // Opcode classification, shared by sequencing and decode.
  logic is_lda;
  logic is_add;
  logic is_sub;
  logic is_out;
  logic is_hlt;

  assign is_lda = (op == OP_LDA);
  assign is_add = (op == OP_ADD);
  assign is_sub = (op == OP_SUB);
  assign is_out = (op == OP_OUT);
  assign is_hlt = (op == OP_HLT);

`ifdef CTRL_VAR_CYCLE_EN
  // Opcodes with no defined execute phase can end right after T4.
  logic is_known;
  assign is_known = is_lda | is_add | is_sub | is_out | is_hlt;
`endif

  assign t_state = t_q;

  // Ring counter and halt flag; clr overrides halt and any mid-instruction position.
  always_ff @(posedge clk) begin
    if (clr) begin
      t_q <= T1;
      hlt <= 1'b0;
    end else if (hlt) begin
      // Machine stopped: hold position until clr.
      t_q <= t_q;
      hlt <= 1'b1;
    end else begin
      case (t_q)
        T1: t_q <= T2;
        T2: t_q <= T3;
        T3: t_q <= T4;
        T4: begin
          if (is_hlt) begin
            // Freeze at T4 with the halt flag raised.
            hlt <= 1'b1;
            t_q <= T4;
          end
`ifdef CTRL_VAR_CYCLE_EN
          else if (is_out || !is_known) begin
            t_q <= T1;
          end
`endif
          else begin
            t_q <= T5;
          end
        end
        T5: begin
`ifdef CTRL_VAR_CYCLE_EN
          if (is_lda) begin
            t_q <= T1;
          end else begin
            t_q <= T6;
          end
`else
          t_q <= T6;
`endif
        end
        T6: t_q <= T1;
        // Any corrupted encoding restarts the fetch cycle.
        default: t_q <= T1;
      endcase
    end
  end

  // Control word decode; everything inactive unless the current state names it, and all inactive while halted.
  always_comb begin
    Cp   = 1'b0;
    Ep   = 1'b0;
    Lm_n = 1'b1;
    CE_n = 1'b1;
    Li_n = 1'b1;
    Ei_n = 1'b1;
    La_n = 1'b1;
    Lb_n = 1'b1;
    Lo_n = 1'b1;
    Ea   = 1'b0;
    Su   = 1'b0;
    Eu   = 1'b0;
    if (!hlt) begin
      case (t_q)
        // Fetch phase ignores op entirely.
        T1: begin
          Ep   = 1'b1;
          Lm_n = 1'b0;
        end
        T2: begin
          Cp = 1'b1;
        end
        T3: begin
          CE_n = 1'b0;
          Li_n = 1'b0;
        end
        // Execute phase: IR address to MAR for memory ops, A to output for OUT.
        T4: begin
          if (is_lda || is_add || is_sub) begin
            Ei_n = 1'b0;
            Lm_n = 1'b0;
          end else if (is_out) begin
            Ea   = 1'b1;
            Lo_n = 1'b0;
          end
        end
        T5: begin
          if (is_lda) begin
            CE_n = 1'b0;
            La_n = 1'b0;
          end else if (is_add || is_sub) begin
            CE_n = 1'b0;
            Lb_n = 1'b0;
          end
        end
        T6: begin
          if (is_add || is_sub) begin
            Eu   = 1'b1;
            La_n = 1'b0;
            Su   = is_sub;
          end
        end
        default: begin
          Cp = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controller_sequencer.sv
// Scoreboarded bench for controller_sequencer: driver queues the expected T-state/control word per cycle,
// a negedge monitor pops and compares, and also checks one-hot ring and single W-bus driver every cycle.
module tb_controller_sequencer;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [3:0] op  = 4'h0;
  logic [5:0] t_state;
  logic Cp, Ep, Lm_n, CE_n, Li_n, Ei_n, La_n, Lb_n, Lo_n, Ea, Su, Eu, hlt;

  controller_sequencer dut (
    .clk(clk), .clr(clr), .op(op), .t_state(t_state),
    .Cp(Cp), .Ep(Ep), .Lm_n(Lm_n), .CE_n(CE_n), .Li_n(Li_n), .Ei_n(Ei_n),
    .La_n(La_n), .Lb_n(Lb_n), .Lo_n(Lo_n), .Ea(Ea), .Su(Su), .Eu(Eu), .hlt(hlt)
  );

  always #5 clk = ~clk;

  // Control word bit order: Cp Ep Lm_n CE_n Li_n Ei_n La_n Lb_n Lo_n Ea Su Eu
  localparam logic [11:0] C_IDLE = 12'b001111111000;
  localparam logic [11:0] C_T1   = 12'b010111111000;
  localparam logic [11:0] C_T2   = 12'b101111111000;
  localparam logic [11:0] C_T3   = 12'b001001111000;
  localparam logic [11:0] C_MEMA = 12'b000110111000;
  localparam logic [11:0] C_LDA5 = 12'b001011011000;
  localparam logic [11:0] C_ADD5 = 12'b001011101000;
  localparam logic [11:0] C_ADD6 = 12'b001111011001;
  localparam logic [11:0] C_SUB6 = 12'b001111011011;
  localparam logic [11:0] C_OUT4 = 12'b001111110100;

  localparam logic [5:0] S1 = 6'b000001;
  localparam logic [5:0] S2 = 6'b000010;
  localparam logic [5:0] S3 = 6'b000100;
  localparam logic [5:0] S4 = 6'b001000;
  localparam logic [5:0] S5 = 6'b010000;
  localparam logic [5:0] S6 = 6'b100000;

  logic [18:0] exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  bit   chk_en      = 1'b0;

  // Drive one cycle's inputs, queue what the DUT must show during this cycle, then move past the edge.
  task automatic cyc(input logic [3:0] o, input logic c, input logic [5:0] ts,
                     input logic h, input logic [11:0] ctl);
    op  = o;
    clr = c;
    exp_q.push_back({ts, h, ctl});
    @(posedge clk);
    #1;
  endtask

  // One full instruction starting at T1; early_op is driven during fetch to show it is ignored.
  task automatic run_instr(input logic [3:0] o, input logic [3:0] early_op);
    cyc(early_op, 1'b0, S1, 1'b0, C_T1);
    cyc(early_op, 1'b0, S2, 1'b0, C_T2);
    cyc(early_op, 1'b0, S3, 1'b0, C_T3);
    case (o)
      4'h1: begin
        cyc(o, 1'b0, S4, 1'b0, C_MEMA);
        cyc(o, 1'b0, S5, 1'b0, C_ADD5);
        cyc(o, 1'b0, S6, 1'b0, C_ADD6);
      end
      4'h2: begin
        cyc(o, 1'b0, S4, 1'b0, C_MEMA);
        cyc(o, 1'b0, S5, 1'b0, C_ADD5);
        cyc(o, 1'b0, S6, 1'b0, C_SUB6);
      end
      4'h0: begin
        cyc(o, 1'b0, S4, 1'b0, C_MEMA);
        cyc(o, 1'b0, S5, 1'b0, C_LDA5);
`ifndef CTRL_VAR_CYCLE_EN
        cyc(o, 1'b0, S6, 1'b0, C_IDLE);
`endif
      end
      4'hE: begin
        cyc(o, 1'b0, S4, 1'b0, C_OUT4);
`ifndef CTRL_VAR_CYCLE_EN
        cyc(o, 1'b0, S5, 1'b0, C_IDLE);
        cyc(o, 1'b0, S6, 1'b0, C_IDLE);
`endif
      end
      default: begin
        cyc(o, 1'b0, S4, 1'b0, C_IDLE);
`ifndef CTRL_VAR_CYCLE_EN
        cyc(o, 1'b0, S5, 1'b0, C_IDLE);
        cyc(o, 1'b0, S6, 1'b0, C_IDLE);
`endif
      end
    endcase
  endtask

  // Monitor: compare every presented cycle against the scoreboard and check structural invariants.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [18:0] act;
      int drivers;
      act = {t_state, hlt, Cp, Ep, Lm_n, CE_n, Li_n, Ei_n, La_n, Lb_n, Lo_n, Ea, Su, Eu};
      if (exp_q.size() != 0) begin
        logic [18:0] exp_v;
        exp_v = exp_q.pop_front();
        vectors++;
        if (act !== exp_v) begin
          miscompares++;
          $display("FAIL vec%0d t_state/hlt/ctl act=%b_%b_%b exp=%b_%b_%b", vectors,
                   act[18:13], act[12], act[11:0], exp_v[18:13], exp_v[12], exp_v[11:0]);
        end
      end
      vectors++;
      if (!$onehot(t_state)) begin
        miscompares++;
        $display("FAIL onehot t_state act=%b exp=one-hot", t_state);
      end
      drivers = int'(Ep) + int'(!Ei_n) + int'(!CE_n) + int'(Ea) + int'(Eu);
      vectors++;
      if (drivers > 1) begin
        miscompares++;
        $display("FAIL wbus drivers act=%0d exp<=1 t_state=%b", drivers, t_state);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL timeout act=not-finished exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    clr = 1'b1;
    op  = 4'h0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    // Reset state, and clr held keeps T1.
    cyc(4'h0, 1'b1, S1, 1'b0, C_T1);
    cyc(4'h3, 1'b1, S1, 1'b0, C_T1);

    // Each opcode once, with a different op driven during fetch.
    run_instr(4'h1, 4'hF);
    run_instr(4'h2, 4'h0);
    run_instr(4'h0, 4'hE);
    run_instr(4'hE, 4'h1);
    run_instr(4'h5, 4'h2);

    // clr in T5 of an ADD aborts it; the following LDA must never pulse Lb_n.
    cyc(4'h1, 1'b0, S1, 1'b0, C_T1);
    cyc(4'h1, 1'b0, S2, 1'b0, C_T2);
    cyc(4'h1, 1'b0, S3, 1'b0, C_T3);
    cyc(4'h1, 1'b0, S4, 1'b0, C_MEMA);
    cyc(4'h1, 1'b1, S5, 1'b0, C_ADD5);
    run_instr(4'h0, 4'h0);

    // HLT: raise hlt after T4, hold T4 quiet for 10 cycles even if op changes, then clr.
    cyc(4'hF, 1'b0, S1, 1'b0, C_T1);
    cyc(4'hF, 1'b0, S2, 1'b0, C_T2);
    cyc(4'hF, 1'b0, S3, 1'b0, C_T3);
    cyc(4'hF, 1'b0, S4, 1'b0, C_IDLE);
    for (int i = 0; i < 10; i++) begin
      cyc((i < 5) ? 4'hF : 4'hE, 1'b0, S4, 1'b1, C_IDLE);
    end
    cyc(4'h1, 1'b1, S4, 1'b1, C_IDLE);
    run_instr(4'h1, 4'h1);
    cyc(4'h0, 1'b0, S1, 1'b0, C_T1);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(negedge clk);
    end
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain act=%0d-pending exp=0-pending", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
